// File: rtl/schoolbook_pkg.sv
// ============================================================================
// Module   : schoolbook_pkg
// Brief    : Shared state encoding and digit-count helper for the
//            digit-serial schoolbook multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package schoolbook_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of multiplier digits, ceil(b_w / digit_w); a zero digit width is
  // mapped to 1 so the illegal-parameter check can report cleanly.
  function automatic int ndig(input int b_w, input int digit_w);
    int dw;
    dw = (digit_w < 1) ? 1 : digit_w;
    return (b_w + dw - 1) / dw;
  endfunction

endpackage

`default_nettype wire

// File: rtl/schoolbook_pp_digit.sv
// ============================================================================
// Module   : schoolbook_pp_digit
// Brief    : Combinational A_W x DIGIT_W partial product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module schoolbook_pp_digit #(
  parameter int A_W     = 224,
  parameter int DIGIT_W = 4
) (
  input  logic [A_W-1:0]         a,
  input  logic [DIGIT_W-1:0]     digit,
  output logic [A_W+DIGIT_W-1:0] pp
);

  // Full-width product; both operands widened so nothing is truncated.
  assign pp = (A_W+DIGIT_W)'(a) * (A_W+DIGIT_W)'(digit);

endmodule

`default_nettype wire

// File: rtl/schoolbook_digit_serial.sv
// ============================================================================
// Module   : schoolbook_digit_serial
// Brief    : Digit-serial unsigned schoolbook multiplier, c = a * b.
//            Consumes DIGIT_W multiplier bits per cycle, LSB digit first.
//            Optional macro SCHOOLBOOK_ZERO_SKIP_EN ends the run early once
//            the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module schoolbook_digit_serial
  import schoolbook_pkg::*;
#(
  parameter int A_W     = 224,
  parameter int B_W     = 224,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic             busy,
  output logic             done,
  output logic [A_W+B_W-1:0] c
);

  localparam int c_ndig  = ndig(B_W, DIGIT_W);
  localparam int c_w     = A_W + B_W;
  localparam int c_bp_w  = c_ndig * DIGIT_W;
  localparam int c_cnt_w = (c_ndig < 2) ? 1 : $clog2(c_ndig + 1);
  localparam int c_sh_w  = $clog2(c_bp_w + 1);

  generate
    if (DIGIT_W < 1 || DIGIT_W > B_W) begin : g_bad_digit_w
      $error("schoolbook_digit_serial: DIGIT_W must be in 1..B_W");
    end
  endgenerate

  state_t               r_state;
  state_t               w_next_state;
  logic [A_W-1:0]       r_a;
  logic [c_bp_w-1:0]    r_b;       // unprocessed multiplier bits, shifted down
  logic [c_w-1:0]       r_acc;
  logic [c_w-1:0]       r_c;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_sh_w-1:0]    r_sh;      // r_cnt * DIGIT_W, kept incrementally

  logic [A_W+DIGIT_W-1:0] w_pp;
  logic [c_w-1:0]       w_pp_ext;
  logic [c_w-1:0]       w_add;
  logic                 w_skip;
  logic                 w_last;
  logic                 w_finish;
  logic                 w_accept;

  schoolbook_pp_digit #(
    .A_W     (A_W),
    .DIGIT_W (DIGIT_W)
  ) u_pp (
    .a     (r_a),
    .digit (r_b[DIGIT_W-1:0]),
    .pp    (w_pp)
  );

`ifdef SCHOOLBOOK_ZERO_SKIP_EN
  // Remaining multiplier is zero: nothing left to add, finish now.
  assign w_skip = (r_b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_pp_ext = c_w'(w_pp);
  assign w_add    = w_skip ? '0 : (w_pp_ext << r_sh);
  assign w_last   = (r_cnt == c_cnt_w'(c_ndig - 1));
  assign w_finish = (r_state == ST_RUN) && (w_skip || w_last);
  assign w_accept = (r_state != ST_RUN) && start;
  assign c        = r_c;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (w_finish) w_next_state = ST_DONE;
      ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, accumulate one digit per RUN cycle,
  // publish the product only on the final RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_c   <= '0;
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= c_bp_w'(b);
      r_acc <= '0;
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= r_acc + w_add;
      r_b   <= r_b >> DIGIT_W;
      r_cnt <= r_cnt + c_cnt_w'(1);
      r_sh  <= r_sh + c_sh_w'(DIGIT_W);
      if (w_finish) r_c <= r_acc + w_add;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_schoolbook_digit_serial.sv
// ============================================================================
// Module   : tb_schoolbook_digit_serial
// Brief    : Directed self-checking bench for schoolbook_digit_serial.
//            Three instances: default (DIGIT_W=4), DIGIT_W=1, and
//            A_W=32/B_W=30/DIGIT_W=7. Expected latencies follow
//            SCHOOLBOOK_ZERO_SKIP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_schoolbook_digit_serial;

  logic clk;
  logic rst;
  logic start_s;
  int   sel;
  logic [255:0] a_s;
  logic [255:0] b_s;

  int checks;
  int errors;

  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [447:0] c0;
  logic [447:0] c1;
  logic [61:0]  c2;

  logic         busy_m;
  logic         done_m;
  logic [511:0] c_m;

  assign start0 = start_s && (sel == 0);
  assign start1 = start_s && (sel == 1);
  assign start2 = start_s && (sel == 2);

  schoolbook_digit_serial #(.A_W(224), .B_W(224), .DIGIT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a_s[223:0]), .b(b_s[223:0]),
    .busy(busy0), .done(done0), .c(c0)
  );

  schoolbook_digit_serial #(.A_W(224), .B_W(224), .DIGIT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a_s[223:0]), .b(b_s[223:0]),
    .busy(busy1), .done(done1), .c(c1)
  );

  schoolbook_digit_serial #(.A_W(32), .B_W(30), .DIGIT_W(7)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a_s[31:0]), .b(b_s[29:0]),
    .busy(busy2), .done(done2), .c(c2)
  );

  always #5 clk = ~clk;

  always_comb begin
    busy_m = busy0;
    done_m = done0;
    c_m    = 512'(c0);
    case (sel)
      1: begin busy_m = busy1; done_m = done1; c_m = 512'(c1); end
      2: begin busy_m = busy2; done_m = done2; c_m = 512'(c2); end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int fixed_lat, input int skip_lat);
`ifdef SCHOOLBOOK_ZERO_SKIP_EN
    return skip_lat;
`else
    return fixed_lat;
`endif
  endfunction

  // Issue start in the current cycle (T), then watch until done.
  // Returns at the falling edge of the done cycle.
  task automatic run_op(input int s, input logic [255:0] av, input logic [255:0] bv,
                        input logic [511:0] exp_c, input logic [511:0] prev_c,
                        input int exp_lat, input int glitch_at, input string tag);
    int n;
    sel = s; a_s = av; b_s = bv; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    n = 1;
    while (1) begin
      @(negedge clk);
      if (n == 1) begin
        check({tag, "_busy_t1"}, 512'(busy_m), 512'(1));
        check({tag, "_c_hold"}, c_m, prev_c);
      end
      if (done_m) break;
      if (n >= exp_lat + 10) begin
        check({tag, "_timeout"}, 512'(0), 512'(1));
        break;
      end
      @(posedge clk); #1;
      if (n + 1 == glitch_at) begin
        start_s = 1'b1; a_s = 256'd1; b_s = 256'd1;
      end else begin
        start_s = 1'b0;
      end
      n++;
    end
    start_s = 1'b0;
    check({tag, "_lat"}, 512'(n), 512'(exp_lat));
    check({tag, "_c"}, c_m, exp_c);
    check({tag, "_busy_done"}, 512'(busy_m), 512'(0));
  endtask

  logic [255:0] all224;
  logic [511:0] p_all;
  logic [511:0] p_mid;
  logic [511:0] p_d2a;
  int           dcnt;

  initial begin
    clk = 1'b0; rst = 1'b0; start_s = 1'b0; sel = 0;
    a_s = '0; b_s = '0; checks = 0; errors = 0;
    all224 = {32'h0, {224{1'b1}}};
    p_all  = (512'd1 << 448) - (512'd1 << 225) + 512'd1;
    p_mid  = (512'd1 << 300) + (512'd1 << 200);
    p_d2a  = (512'd1 << 62) - (512'd1 << 32) - (512'd1 << 30) + 512'd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c0", 512'(c0), 512'(0));
    check("rst_busy0", 512'(busy0), 512'(0));
    check("rst_done0", 512'(done0), 512'(0));
    check("rst_c2", 512'(c2), 512'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Default instance, NDIG = 56.
    run_op(0, all224, all224, p_all, 512'd0, lat(57, 57), 0, "all1");
    @(posedge clk); #1;
    run_op(0, 256'd3, 256'd5, 512'd15, p_all, lat(57, 3), 0, "3x5");
    @(posedge clk); #1;
    run_op(0, 256'hDEAD_BEEF, 256'd0, 512'd0, 512'd15, lat(57, 2), 0, "b0");
    @(posedge clk); #1;
    run_op(0, 256'd0, 256'd7, 512'd0, 512'd0, lat(57, 3), 0, "a0");
    @(posedge clk); #1;
    run_op(0, 256'd1 << 200, (256'd1 << 100) + 256'd1, p_mid, 512'd0, lat(57, 28), 0, "mid");
    @(posedge clk); #1;

    // Start re-pulsed at T+10 with other operands must be ignored.
    run_op(0, all224, all224, p_all, p_mid, lat(57, 57), 10, "restart");
    @(posedge clk);
    @(negedge clk);
    check("restart_done_once", 512'(done0), 512'(0));
    check("restart_idle", 512'(busy0), 512'(0));
    @(posedge clk); #1;

    // Reset at T+20 mid-operation, with start held high during reset.
    sel = 0; a_s = all224; b_s = all224; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b0; start_s = 1'b1; a_s = 256'd3; b_s = 256'd5;
    @(posedge clk); #1;
    rst = 1'b1; start_s = 1'b0;
    @(negedge clk);
    check("mrst_c", 512'(c0), 512'(0));
    check("mrst_busy", 512'(busy0), 512'(0));
    check("mrst_done", 512'(done0), 512'(0));
    dcnt = 0;
    repeat (70) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    check("mrst_no_done", 512'(dcnt), 512'(0));
    @(posedge clk); #1;
    run_op(0, 256'd3, 256'd5, 512'd15, 512'd0, lat(57, 3), 0, "after_rst");
    @(posedge clk); #1;

    // Back-to-back: second start issued in the DONE cycle.
    run_op(0, 256'd3, 256'd5, 512'd15, 512'd15, lat(57, 3), 0, "b2b0_1");
    run_op(0, 256'hDEAD, 256'd0, 512'd0, 512'd15, lat(57, 2), 0, "b2b0_2");
    @(posedge clk); #1;

    // DIGIT_W = 1, NDIG = 224.
    run_op(1, 256'd3, 256'd5, 512'd15, 512'd0, lat(225, 5), 0, "b2b1_1");
    run_op(1, all224, all224, p_all, 512'd15, lat(225, 225), 0, "b2b1_2");
    @(posedge clk); #1;

    // A_W = 32, B_W = 30, DIGIT_W = 7: NDIG = 5 with a padded top digit.
    run_op(2, 256'hFFFF_FFFF, 256'h3FFF_FFFF, p_d2a, 512'd0, lat(6, 6), 0, "b2b2_1");
    run_op(2, 256'h1234_5678, 256'h80, 512'h9_1A2B_3C00, p_d2a, lat(6, 4), 0, "b2b2_2");
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
